// File: rtl/axi4_sim_mem_slave.sv
// ============================================================================
// axi4_sim_mem_slave: behavioural AXI4 memory slave (INCR bursts, one burst per direction).
// Rev 1.0
// ============================================================================
`default_nettype none

module axi4_sim_mem_slave #(
  parameter int ADDR_BITS    = 32,
  parameter int DATA_BITS    = 64,
  parameter int ID_BITS      = 4,
  parameter int DEPTH_WORDS  = 4096,
  parameter int READ_LATENCY = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   ar_valid,
  output logic                   ar_ready,
  input  logic [ADDR_BITS-1:0]   ar_bits_addr,
  input  logic [ID_BITS-1:0]     ar_bits_id,
  input  logic [2:0]             ar_bits_size,
  input  logic [7:0]             ar_bits_len,
  input  logic                   aw_valid,
  output logic                   aw_ready,
  input  logic [ADDR_BITS-1:0]   aw_bits_addr,
  input  logic [ID_BITS-1:0]     aw_bits_id,
  input  logic [2:0]             aw_bits_size,
  input  logic [7:0]             aw_bits_len,
  input  logic                   w_valid,
  output logic                   w_ready,
  input  logic [DATA_BITS-1:0]   w_bits_data,
  input  logic [DATA_BITS/8-1:0] w_bits_strb,
  input  logic                   w_bits_last,
  output logic                   r_valid,
  input  logic                   r_ready,
  output logic [DATA_BITS-1:0]   r_bits_data,
  output logic [ID_BITS-1:0]     r_bits_id,
  output logic [1:0]             r_bits_resp,
  output logic                   r_bits_last,
  output logic                   b_valid,
  input  logic                   b_ready,
  output logic [ID_BITS-1:0]     b_bits_id,
  output logic [1:0]             b_bits_resp
);

  localparam int STRB_BITS = DATA_BITS / 8;
  localparam int LANE_LOG  = $clog2(STRB_BITS);
  localparam int IDX_BITS  = $clog2(DEPTH_WORDS);
  localparam int WAIT_W    = (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY);
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    (READ_LATENCY == 0) ? '0 : WAIT_W'(READ_LATENCY - 1);
  localparam logic [2:0] MAX_SIZE    = 3'(LANE_LOG);
  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;

  localparam logic [1:0] RIDLE = 2'd0;
  localparam logic [1:0] RWAIT = 2'd1;
  localparam logic [1:0] RBEAT = 2'd2;
  localparam logic [1:0] WIDLE = 2'd0;
  localparam logic [1:0] WDATA = 2'd1;
  localparam logic [1:0] WRESP = 2'd2;

  function automatic logic [ADDR_BITS-1:0] beat_step(input logic [2:0] size);
    return ADDR_BITS'(1) << size;
  endfunction

  logic [DATA_BITS-1:0] mem [DEPTH_WORDS];

  // ---------------------------------------------------------------- read path
  logic [1:0]           rd_state, rd_state_nxt;
  logic [ADDR_BITS-1:0] rd_addr;
  logic [ID_BITS-1:0]   rd_id;
  logic [2:0]           rd_size;
  logic [7:0]           rd_len, rd_cnt;
  logic [WAIT_W-1:0]    wait_cnt;
  logic                 ar_hs, r_hs, wait_done;
  logic                 load_en, load_sz_ok;
  logic [ADDR_BITS-1:0] load_addr;
  logic [7:0]           load_cnt, load_len;
  logic [2:0]           load_size;
  logic [IDX_BITS-1:0]  rd_idx;

  assign ar_hs      = ar_valid & ar_ready;
  assign r_hs       = r_valid & r_ready;
  assign wait_done  = (wait_cnt == WAIT_LAST);
  assign load_sz_ok = (load_size <= MAX_SIZE);
  assign rd_idx     = load_addr[LANE_LOG +: IDX_BITS];
  assign r_bits_id  = rd_id;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rd_state <= RIDLE;
    else        rd_state <= rd_state_nxt;
  end

  always_comb begin
    rd_state_nxt = rd_state;
    case (rd_state)
      RIDLE:   if (ar_hs) rd_state_nxt = (READ_LATENCY == 0) ? RBEAT : RWAIT;
      RWAIT:   if (wait_done) rd_state_nxt = RBEAT;
      RBEAT:   if (r_hs && r_bits_last) rd_state_nxt = RIDLE;
      default: rd_state_nxt = RIDLE;
    endcase
  end

  always_comb begin
    ar_ready = 1'b0;
    r_valid  = 1'b0;
    case (rd_state)
      RIDLE:   ar_ready = reset;
      RBEAT:   r_valid  = 1'b1;
      default: ;
    endcase
  end

  // Beat source selection: first beat from the request (zero latency) or the
  // latched address; later beats step forward on each accepted beat.
  always_comb begin
    load_en   = 1'b0;
    load_addr = rd_addr;
    load_cnt  = rd_cnt;
    load_len  = rd_len;
    load_size = rd_size;
    case (rd_state)
      RIDLE: if (ar_hs && (READ_LATENCY == 0)) begin
        load_en   = 1'b1;
        load_addr = ar_bits_addr;
        load_cnt  = 8'd0;
        load_len  = ar_bits_len;
        load_size = ar_bits_size;
      end
      RWAIT: if (wait_done) begin
        load_en  = 1'b1;
        load_cnt = 8'd0;
      end
      RBEAT: if (r_hs && !r_bits_last) begin
        load_en   = 1'b1;
        load_addr = rd_addr + beat_step(rd_size);
        load_cnt  = rd_cnt + 8'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_addr     <= '0;
      rd_id       <= '0;
      rd_size     <= '0;
      rd_len      <= '0;
      rd_cnt      <= '0;
      wait_cnt    <= '0;
      r_bits_data <= '0;
      r_bits_resp <= RESP_OKAY;
      r_bits_last <= 1'b0;
    end else begin
      if (ar_hs) begin
        rd_addr  <= ar_bits_addr;
        rd_id    <= ar_bits_id;
        rd_size  <= ar_bits_size;
        rd_len   <= ar_bits_len;
        rd_cnt   <= '0;
        wait_cnt <= '0;
      end else if (rd_state == RWAIT && !wait_done) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
      if (load_en) begin
        rd_addr     <= load_addr;
        rd_cnt      <= load_cnt;
        r_bits_data <= load_sz_ok ? mem[rd_idx] : '0;
        r_bits_resp <= load_sz_ok ? RESP_OKAY : RESP_SLVERR;
        r_bits_last <= (load_cnt == load_len);
      end
    end
  end

  // --------------------------------------------------------------- write path
  logic [1:0]           wr_state, wr_state_nxt;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [ID_BITS-1:0]   wr_id;
  logic [2:0]           wr_size;
  logic [7:0]           wr_len, wr_cnt;
  logic                 wr_err;
  logic                 aw_hs, w_hs, wr_sz_ok, wr_at_len, w_end;
  logic [IDX_BITS-1:0]  wr_idx;

  assign aw_hs     = aw_valid & aw_ready;
  assign w_hs      = w_valid & w_ready;
  assign wr_sz_ok  = (wr_size <= MAX_SIZE);
  assign wr_at_len = (wr_cnt == wr_len);
  assign w_end     = w_bits_last | wr_at_len;
  assign wr_idx    = wr_addr[LANE_LOG +: IDX_BITS];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) wr_state <= WIDLE;
    else        wr_state <= wr_state_nxt;
  end

  always_comb begin
    wr_state_nxt = wr_state;
    case (wr_state)
      WIDLE:   if (aw_hs) wr_state_nxt = WDATA;
      WDATA:   if (w_hs && w_end) wr_state_nxt = WRESP;
      WRESP:   if (b_ready) wr_state_nxt = WIDLE;
      default: wr_state_nxt = WIDLE;
    endcase
  end

  always_comb begin
    aw_ready    = 1'b0;
    w_ready     = 1'b0;
    b_valid     = 1'b0;
    b_bits_id   = wr_id;
    b_bits_resp = wr_err ? RESP_SLVERR : RESP_OKAY;
    case (wr_state)
      WIDLE:   aw_ready = reset;
      WDATA:   w_ready  = 1'b1;
      WRESP:   b_valid  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_addr <= '0;
      wr_id   <= '0;
      wr_size <= '0;
      wr_len  <= '0;
      wr_cnt  <= '0;
      wr_err  <= 1'b0;
    end else if (aw_hs) begin
      wr_addr <= aw_bits_addr;
      wr_id   <= aw_bits_id;
      wr_size <= aw_bits_size;
      wr_len  <= aw_bits_len;
      wr_cnt  <= '0;
      wr_err  <= 1'b0;
    end else if (w_hs) begin
      wr_addr <= wr_addr + beat_step(wr_size);
      if (!w_end) wr_cnt <= wr_cnt + 8'd1;
      // An early or missing w_last is flagged but still honoured.
      if (!wr_sz_ok || (w_bits_last != wr_at_len)) wr_err <= 1'b1;
    end
  end

  // Backing store has no reset so contents survive a reset pulse.
  always_ff @(posedge clock) begin
    if (w_hs && wr_sz_ok) begin
      for (int i = 0; i < STRB_BITS; i++) begin
        if (w_bits_strb[i]) mem[wr_idx][i*8 +: 8] <= w_bits_data[i*8 +: 8];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axi4_sim_mem_slave.sv
// ============================================================================
// tb_axi4_sim_mem_slave: directed scoreboard bench for axi4_sim_mem_slave.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_axi4_sim_mem_slave;
  localparam int AB = 32;
  localparam int DB = 64;
  localparam int IB = 4;
  localparam int DW = 4096;
  localparam int RL = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          ar_valid = 1'b0, ar_ready;
  logic [AB-1:0] ar_bits_addr = '0;
  logic [IB-1:0] ar_bits_id = '0;
  logic [2:0]    ar_bits_size = '0;
  logic [7:0]    ar_bits_len = '0;
  logic          aw_valid = 1'b0, aw_ready;
  logic [AB-1:0] aw_bits_addr = '0;
  logic [IB-1:0] aw_bits_id = '0;
  logic [2:0]    aw_bits_size = '0;
  logic [7:0]    aw_bits_len = '0;
  logic          w_valid = 1'b0, w_ready;
  logic [DB-1:0] w_bits_data = '0;
  logic [7:0]    w_bits_strb = '0;
  logic          w_bits_last = 1'b0;
  logic          r_valid, r_ready = 1'b0;
  logic [DB-1:0] r_bits_data;
  logic [IB-1:0] r_bits_id;
  logic [1:0]    r_bits_resp;
  logic          r_bits_last;
  logic          b_valid, b_ready = 1'b0;
  logic [IB-1:0] b_bits_id;
  logic [1:0]    b_bits_resp;

  always #5 clock = ~clock;

  axi4_sim_mem_slave #(
    .ADDR_BITS(AB), .DATA_BITS(DB), .ID_BITS(IB), .DEPTH_WORDS(DW), .READ_LATENCY(RL)
  ) dut (
    .clock(clock), .reset(reset),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_bits_addr(ar_bits_addr),
    .ar_bits_id(ar_bits_id), .ar_bits_size(ar_bits_size), .ar_bits_len(ar_bits_len),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_bits_addr(aw_bits_addr),
    .aw_bits_id(aw_bits_id), .aw_bits_size(aw_bits_size), .aw_bits_len(aw_bits_len),
    .w_valid(w_valid), .w_ready(w_ready), .w_bits_data(w_bits_data),
    .w_bits_strb(w_bits_strb), .w_bits_last(w_bits_last),
    .r_valid(r_valid), .r_ready(r_ready), .r_bits_data(r_bits_data),
    .r_bits_id(r_bits_id), .r_bits_resp(r_bits_resp), .r_bits_last(r_bits_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_bits_id(b_bits_id), .b_bits_resp(b_bits_resp)
  );

  typedef struct {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } beat_t;

  beat_t       exp_q[$];
  logic [63:0] shadow [DW];
  logic [63:0] wbuf [256];
  int          vecs = 0;
  int          errs = 0;

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 3) % DW);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input logic [2:0] size,
                          input logic [7:0] len, input logic [7:0] strb, input int last_at,
                          input logic [1:0] exp_resp, input string tag);
    int n;
    aw_valid = 1'b1; aw_bits_addr = addr; aw_bits_id = id;
    aw_bits_size = size; aw_bits_len = len;
    n = 0;
    while (!aw_ready && n < 50) begin tick(); n++; end
    check({tag, "_aw_ready"}, 64'(aw_ready), 64'd1);
    tick();
    aw_valid = 1'b0;
    for (int b = 0; b <= last_at; b++) begin
      w_valid = 1'b1; w_bits_data = wbuf[b]; w_bits_strb = strb;
      w_bits_last = (b == last_at);
      n = 0;
      while (!w_ready && n < 50) begin tick(); n++; end
      tick();
      if (size <= 3'd3)
        for (int k = 0; k < 8; k++)
          if (strb[k]) shadow[widx(addr + 32'(b << size))][k*8 +: 8] = wbuf[b][k*8 +: 8];
    end
    w_valid = 1'b0; w_bits_last = 1'b0;
    b_ready = 1'b1;
    n = 0;
    while (!b_valid && n < 50) begin tick(); n++; end
    check({tag, "_b_valid"}, 64'(b_valid), 64'd1);
    check({tag, "_b_resp"}, 64'(b_bits_resp), 64'(exp_resp));
    check({tag, "_b_id"}, 64'(b_bits_id), 64'(id));
    tick();
    b_ready = 1'b0;
  endtask

  task automatic issue_ar(input logic [31:0] addr, input logic [3:0] id, input logic [2:0] size,
                          input logic [7:0] len, input string tag);
    int n;
    beat_t e;
    for (int b = 0; b <= int'(len); b++) begin
      e.data = (size <= 3'd3) ? shadow[widx(addr + 32'(b << size))] : 64'd0;
      e.resp = (size <= 3'd3) ? 2'd0 : 2'd2;
      e.last = (b == int'(len));
      e.id   = id;
      exp_q.push_back(e);
    end
    ar_valid = 1'b1; ar_bits_addr = addr; ar_bits_id = id;
    ar_bits_size = size; ar_bits_len = len;
    n = 0;
    while (!ar_ready && n < 50) begin tick(); n++; end
    check({tag, "_ar_ready"}, 64'(ar_ready), 64'd1);
    tick();
    ar_valid = 1'b0;
  endtask

  // Returns one cycle after each beat handshake; first-beat wait is measured from AR accept.
  task automatic collect(input int nbeats, input int stall_beat, input int stall_cycles,
                         input bit check_lat, input string tag);
    int n;
    beat_t e;
    r_ready = 1'b1;
    for (int b = 0; b < nbeats; b++) begin
      n = 0;
      while (!r_valid && n < 50) begin tick(); n++; end
      if (b == 0 && check_lat) check({tag, "_latency"}, 64'(n), 64'(RL));
      check({tag, "_r_valid"}, 64'(r_valid), 64'd1);
      if (b == stall_beat) begin
        r_ready = 1'b0;
        for (int s = 0; s < stall_cycles; s++) begin
          tick();
          check({tag, "_stall_valid"}, 64'(r_valid), 64'd1);
          if (exp_q.size() > 0) check({tag, "_stall_data"}, r_bits_data, exp_q[0].data);
        end
        r_ready = 1'b1;
      end
      if (exp_q.size() == 0) begin
        check({tag, "_unexpected_beat"}, 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check({tag, "_data"}, r_bits_data, e.data);
        check({tag, "_resp"}, 64'(r_bits_resp), 64'(e.resp));
        check({tag, "_last"}, 64'(r_bits_last), 64'(e.last));
        check({tag, "_id"}, 64'(r_bits_id), 64'(e.id));
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) tick();
    check("rst_ar_ready", 64'(ar_ready), 64'd0);
    check("rst_aw_ready", 64'(aw_ready), 64'd0);
    check("rst_r_valid", 64'(r_valid), 64'd0);
    check("rst_b_valid", 64'(b_valid), 64'd0);
    check("rst_r_data", r_bits_data, 64'd0);
    reset = 1'b1;
    tick();
    check("post_rst_ar_ready", 64'(ar_ready), 64'd1);
    check("post_rst_aw_ready", 64'(aw_ready), 64'd1);

    // Write then read back a 4-beat burst
    wbuf[0] = 64'h11; wbuf[1] = 64'h22; wbuf[2] = 64'h33; wbuf[3] = 64'h44;
    do_write(32'h40, 4'd3, 3'd3, 8'd3, 8'hFF, 3, 2'd0, "wr_basic");
    issue_ar(32'h40, 4'd5, 3'd3, 8'd3, "rd_basic");
    collect(4, -1, 0, 1'b0, "rd_basic");

    // Latency and backpressure on the first beat
    issue_ar(32'h40, 4'd6, 3'd3, 8'd3, "rd_stall");
    collect(4, 0, 3, 1'b1, "rd_stall");

    // Partial strobe over an all-ones word
    wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    do_write(32'h100, 4'd1, 3'd3, 8'd0, 8'hFF, 0, 2'd0, "wr_ones");
    wbuf[0] = 64'hAABB_CCDD_EEFF_0011;
    do_write(32'h100, 4'd2, 3'd3, 8'd0, 8'h0F, 0, 2'd0, "wr_strb");
    issue_ar(32'h100, 4'd7, 3'd3, 8'd0, "rd_strb");
    collect(1, -1, 0, 1'b0, "rd_strb");
    check("strb_model", shadow[widx(32'h100)], 64'hFFFF_FFFF_EEFF_0011);

    // Early w_last, oversize read, oversize write
    wbuf[0] = 64'h5555; wbuf[1] = 64'h6666;
    do_write(32'h300, 4'd9, 3'd3, 8'd3, 8'hFF, 1, 2'd2, "wr_early_last");
    issue_ar(32'h40, 4'd1, 3'd4, 8'd3, "rd_size4");
    collect(4, -1, 0, 1'b0, "rd_size4");
    wbuf[0] = 64'hDEAD_DEAD_DEAD_DEAD;
    do_write(32'h40, 4'd4, 3'd4, 8'd0, 8'hFF, 0, 2'd2, "wr_size4");
    issue_ar(32'h40, 4'd2, 3'd3, 8'd1, "rd_after_size4");
    collect(2, -1, 0, 1'b0, "rd_after_size4");

    // Address wrap onto word 0
    wbuf[0] = 64'hCAFE_F00D_0000_0001;
    do_write(32'h0, 4'd0, 3'd3, 8'd0, 8'hFF, 0, 2'd0, "wr_word0");
    issue_ar(32'(DW * 8), 4'd8, 3'd3, 8'd0, "rd_wrap");
    collect(1, -1, 0, 1'b0, "rd_wrap");

    // Same-cycle write and first-beat load of one word: read sees old data
    wbuf[0] = 64'h0123_4567_89AB_CDEF;
    do_write(32'h500, 4'd1, 3'd3, 8'd0, 8'hFF, 0, 2'd0, "wr_coll_old");
    r_ready = 1'b0;
    aw_valid = 1'b1; aw_bits_addr = 32'h500; aw_bits_id = 4'd3;
    aw_bits_size = 3'd3; aw_bits_len = 8'd0;
    check("coll_aw_ready", 64'(aw_ready), 64'd1);
    tick();
    aw_valid = 1'b0;
    ar_valid = 1'b1; ar_bits_addr = 32'h500; ar_bits_id = 4'd2;
    ar_bits_size = 3'd3; ar_bits_len = 8'd0;
    check("coll_ar_ready", 64'(ar_ready), 64'd1);
    tick();
    ar_valid = 1'b0;
    tick();
    w_valid = 1'b1; w_bits_data = 64'hFEDC_BA98_7654_3210; w_bits_strb = 8'hFF; w_bits_last = 1'b1;
    tick();
    w_valid = 1'b0; w_bits_last = 1'b0;
    check("coll_r_valid", 64'(r_valid), 64'd1);
    check("coll_old_data", r_bits_data, 64'h0123_4567_89AB_CDEF);
    r_ready = 1'b1;
    tick();
    check("coll_r_done", 64'(r_valid), 64'd0);
    b_ready = 1'b1;
    check("coll_b_valid", 64'(b_valid), 64'd1);
    check("coll_b_resp", 64'(b_bits_resp), 64'd0);
    tick();
    b_ready = 1'b0;
    shadow[widx(32'h500)] = 64'hFEDC_BA98_7654_3210;
    issue_ar(32'h500, 4'd2, 3'd3, 8'd0, "rd_coll_new");
    collect(1, -1, 0, 1'b0, "rd_coll_new");

    // Reset in the middle of an 8-beat read
    for (int i = 0; i < 8; i++) wbuf[i] = 64'h1000 + 64'(i * 17);
    do_write(32'h600, 4'd6, 3'd3, 8'd7, 8'hFF, 7, 2'd0, "wr_8beat");
    issue_ar(32'h600, 4'd4, 3'd3, 8'd7, "rd_abort");
    collect(2, -1, 0, 1'b0, "rd_abort");
    check("abort_pre_valid", 64'(r_valid), 64'd1);
    reset = 1'b0;
    #1;
    check("abort_r_valid", 64'(r_valid), 64'd0);
    check("abort_r_data", r_bits_data, 64'd0);
    check("abort_ar_ready", 64'(ar_ready), 64'd0);
    exp_q.delete();
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("abort_rel_ar_ready", 64'(ar_ready), 64'd1);
    check("abort_rel_r_valid", 64'(r_valid), 64'd0);
    issue_ar(32'h600, 4'd4, 3'd3, 8'd7, "rd_intact");
    collect(8, -1, 0, 1'b0, "rd_intact");
    n = exp_q.size();
    check("scoreboard_empty", 64'(n), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

`default_nettype wire
